// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - FIFO controller sequencing one dual-port RAM with a registered read
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 39,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  FIFO_clk,
    input  logic                  FIFO_rst,
    input  logic                  FIFO_flush,
    input  logic                  FIFO_wr_en,
    input  logic [DATA_WIDTH-1:0] FIFO_wr_data,
    output logic                  FIFO_full,
    output logic                  FIFO_almost_full,
    input  logic                  FIFO_rd_en,
    output logic [DATA_WIDTH-1:0] FIFO_rd_data,
    output logic                  FIFO_rd_valid,
    output logic                  FIFO_empty,
    output logic                  FIFO_almost_empty,
    output logic [ADDR_WIDTH:0]   FIFO_count,
    output logic                  FIFO_overflow,
    output logic                  FIFO_underflow,
    output logic                  RAM_rstn,
    output logic                  RAM_en,
    output logic                  RAM_wr_en,
    output logic [ADDR_WIDTH-1:0] RAM_wr_addr,
    output logic [DATA_WIDTH-1:0] RAM_wr_data,
    output logic                  RAM_rd_en,
    output logic [ADDR_WIDTH-1:0] RAM_rd_addr,
    input  logic [DATA_WIDTH-1:0] RAM_rd_data
);

    localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_rd_valid;
    logic                r_overflow;
    logic                r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    // Reset also gates the accepts so the RAM sees no strobes while reset is held.
    assign w_wr_acc = FIFO_wr_en & ~w_full  & ~FIFO_flush & ~FIFO_rst;
    assign w_rd_acc = FIFO_rd_en & ~w_empty & ~FIFO_flush & ~FIFO_rst;

    always_ff @(posedge FIFO_clk) begin
        if (FIFO_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (FIFO_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_rd_valid <= w_rd_acc;
            if (FIFO_wr_en && w_full)  r_overflow  <= 1'b1;
            if (FIFO_rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    assign FIFO_full         = w_full;
    assign FIFO_empty        = w_empty;
    assign FIFO_almost_full  = (r_count >= AF_C);
    assign FIFO_almost_empty = (r_count <= AE_C);
    assign FIFO_count        = r_count;
    assign FIFO_overflow     = r_overflow;
    assign FIFO_underflow    = r_underflow;
    // A read still in flight when reset arrives is dropped immediately.
    assign FIFO_rd_valid     = r_rd_valid & ~FIFO_rst;
    assign FIFO_rd_data      = FIFO_rd_valid ? RAM_rd_data : '0;

    assign RAM_rstn    = ~FIFO_rst;
    assign RAM_en      = 1'b1;
    assign RAM_wr_en   = w_wr_acc;
    assign RAM_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign RAM_wr_data = FIFO_wr_data;
    assign RAM_rd_en   = w_rd_acc;
    assign RAM_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl with a behavioural RAM and queue model
module tb_sync_fifo_ctrl;

    localparam int DW = 39;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, flush, wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic          full, afull, empty, aempty, rd_valid, ovf, unf;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          ram_rstn, ram_en, ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .FIFO_clk(clk), .FIFO_rst(rst), .FIFO_flush(flush),
        .FIFO_wr_en(wr_en), .FIFO_wr_data(wr_data),
        .FIFO_full(full), .FIFO_almost_full(afull),
        .FIFO_rd_en(rd_en), .FIFO_rd_data(rd_data), .FIFO_rd_valid(rd_valid),
        .FIFO_empty(empty), .FIFO_almost_empty(aempty), .FIFO_count(count),
        .FIFO_overflow(ovf), .FIFO_underflow(unf),
        .RAM_rstn(ram_rstn), .RAM_en(ram_en),
        .RAM_wr_en(ram_wr_en), .RAM_wr_addr(ram_wr_addr), .RAM_wr_data(ram_wr_data),
        .RAM_rd_en(ram_rd_en), .RAM_rd_addr(ram_rd_addr), .RAM_rd_data(ram_rd_data)
    );

    // RAM: registered read, output zero when not reading
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_rstn) ram_rd_data <= '0;
        else if (ram_en) begin
            if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
            ram_rd_data <= ram_rd_en ? mem[ram_rd_addr] : '0;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words plus error flags and a read-return slot
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_data;
    int            m_wa, m_ra;
    bit            chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0; m_wa = 0; m_ra = 0;
        end else if (flush) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_valid = 0; m_wa = 0; m_ra = 0;
        end else begin
            bit f, e, wa, ra;
            f  = (q.size() == DEPTH);
            e  = (q.size() == 0);
            wa = wr_en && !f;
            ra = rd_en && !e;
            if (wr_en && f) m_ovf = 1;
            if (rd_en && e) m_unf = 1;
            m_valid = ra;
            if (ra) begin m_data = q.pop_front(); m_ra = (m_ra + 1) % DEPTH; end
            if (wa) begin q.push_back(wr_data); m_wa = (m_wa + 1) % DEPTH; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            bit ev;
            sz = q.size();
            ev = m_valid && !rst;
            chk("count",        count,       64'(sz));
            chk("empty",        empty,       64'(sz == 0));
            chk("full",         full,        64'(sz == DEPTH));
            chk("almost_full",  afull,       64'(sz >= DEPTH - 2));
            chk("almost_empty", aempty,      64'(sz <= 2));
            chk("overflow",     ovf,         64'(m_ovf));
            chk("underflow",    unf,         64'(m_unf));
            chk("rd_valid",     rd_valid,    64'(ev));
            chk("rd_data",      rd_data,     ev ? 64'(m_data) : 64'd0);
            chk("ram_rstn",     ram_rstn,    64'(!rst));
            chk("ram_en",       ram_en,      64'd1);
            chk("ram_wr_en",    ram_wr_en,   64'(wr_en && sz < DEPTH && !flush && !rst));
            chk("ram_rd_en",    ram_rd_en,   64'(rd_en && sz > 0 && !flush && !rst));
            chk("ram_wr_addr",  ram_wr_addr, 64'(m_wa));
            chk("ram_rd_addr",  ram_rd_addr, 64'(m_ra));
            chk("ram_wr_data",  ram_wr_data, 64'(wr_data));
        end
    end

    logic [DW-1:0] got[$];
    always @(negedge clk) if (rd_valid) got.push_back(rd_data);

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic s);
        wr_en = w; wr_data = d; rd_en = r; flush = f; rst = s;
        #2;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        drive(w, d, r, 1'b0, 1'b0); tick();
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        // 1 reset with both requests active
        drive(1, 39'h1, 1, 0, 1);
        @(posedge clk); #1; chk_en = 1;
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ram_rstn", ram_rstn, 0);
        chk("rst_ram_wr_en", ram_wr_en, 0);

        // 2 fill
        for (int i = 0; i < 16; i++) begin
            step(1, DW'(i), 0);
            if (i == 12) chk("af_at_13", afull, 0);
            if (i == 13) chk("af_at_14", afull, 1);
        end
        chk("fill_full", full, 1);
        drive(1, 39'h77, 0, 0, 0);
        chk("ovf_no_wr", ram_wr_en, 0);
        tick();
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 16);

        // 3 drain
        got.delete();
        for (int i = 0; i < 16; i++) begin
            step(0, '0, 1);
            chk("drain_valid", rd_valid, 1);
            if (i == 12) chk("ae_at_3", aempty, 0);
            if (i == 13) chk("ae_at_2", aempty, 1);
        end
        chk("drain_empty", empty, 1);
        step(0, '0, 1);
        chk("unf_set", unf, 1);
        chk("unf_no_valid", rd_valid, 0);
        chk("drain_len", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("drain_data", got[i], i);

        // 4 wrap from a clean state
        drive(0, '0, 0, 1, 0); tick();
        for (int i = 0; i < 10; i++) step(1, DW'(100 + i), 0);
        for (int i = 0; i < 10; i++) step(0, '0, 1);
        step(0, '0, 0);
        got.delete();
        exp_addr = 4'd10;
        for (int i = 0; i < 10; i++) begin
            drive(1, 39'h5A00000000 + DW'(i), 0, 0, 0);
            chk("wrap_addr", ram_wr_addr, exp_addr);
            exp_addr = exp_addr + 1'b1;
            tick();
        end
        chk("wrap_count", count, 10);
        for (int i = 0; i < 10; i++) step(0, '0, 1);
        step(0, '0, 0);
        chk("wrap_len", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk("wrap_data", got[i], 39'h5A00000000 + i);

        // 5 simultaneous at full and at empty
        for (int i = 0; i < 16; i++) step(1, DW'(200 + i), 0);
        step(1, 39'h99, 1);
        chk("sim_full_count", count, 15);
        chk("sim_full_ovf", ovf, 1);
        chk("sim_full_valid", rd_valid, 1);
        chk("sim_full_data", rd_data, 200);
        for (int i = 0; i < 15; i++) step(0, '0, 1);
        step(0, '0, 0);
        chk("sim_pre_empty", empty, 1);
        step(1, 39'h55, 1);
        chk("sim_empty_count", count, 1);
        chk("sim_empty_unf", unf, 1);
        chk("sim_empty_valid", rd_valid, 0);

        // 6 flush with a pending read request
        for (int i = 0; i < 15; i++) step(1, DW'(300 + i), 0);
        step(1, 39'h1, 0);
        for (int i = 0; i < 11; i++) step(0, '0, 1);
        chk("pre_flush_count", count, 5);
        chk("pre_flush_ovf", ovf, 1);
        drive(0, '0, 1, 1, 0);
        tick();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ovf", ovf, 0);
        chk("flush_valid", rd_valid, 0);
        drive(1, 39'h42, 0, 0, 0);
        chk("flush_wr_addr", ram_wr_addr, 0);
        tick();
        step(0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
